// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared FIFO read-side constants, packer FSM states and lane mask helper
package fifo_pkg;

    localparam int FIFO_DATASIZE = 8;
    localparam int FIFO_ADDRSIZE = 4;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        FLUSH_WAIT = 2'd1,
        FLUSH_EMIT = 2'd2
    } flush_state_e;

    // Low n bits set; callers truncate to their lane count.
    function automatic logic [31:0] lane_mask(input int unsigned n);
        if (n >= 32) begin
            return '1;
        end
        return (32'd1 << n) - 32'd1;
    endfunction

endpackage

// File: rtl/fifo_word_out_reg.sv
// rtl/fifo_word_out_reg.sv - valid/ready output holding register for packed words
module fifo_word_out_reg #(
    parameter int DATA_W = 32,
    parameter int KEEP_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic [KEEP_W-1:0] load_keep,
    input  logic              ready,
    output logic [DATA_W-1:0] data,
    output logic [KEEP_W-1:0] keep,
    output logic              valid
);

    always_ff @(posedge clk) begin
        if (rst) begin
            data  <= '0;
            keep  <= '0;
            valid <= 1'b0;
        end else if (load) begin
            data  <= load_data;
            keep  <= load_keep;
            valid <= 1'b1;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fifo_rd_word_packer.sv
// rtl/fifo_rd_word_packer.sv - drains FIFO bytes and packs them into words with flush support
module fifo_rd_word_packer
    import fifo_pkg::*;
#(
    parameter int                  DATASIZE       = FIFO_DATASIZE,
    parameter int                  BYTES_PER_WORD = 4,
    parameter logic [DATASIZE-1:0] PAD_BYTE       = '0,
    parameter int                  CNT_W          = 16
) (
    input  logic                               i_rd_clk,
    input  logic                               i_rd_rst,
    input  logic                               i_empty,
    output logic                               o_rd_en,
    input  logic [DATASIZE-1:0]                i_rd_data,
    input  logic                               i_flush,
    output logic [DATASIZE*BYTES_PER_WORD-1:0] o_word_data,
    output logic [BYTES_PER_WORD-1:0]          o_word_keep,
    output logic                               o_word_valid,
    input  logic                               i_word_ready,
    output logic                               o_flush_done,
    output logic [CNT_W-1:0]                   o_word_cnt
);

    localparam int BPW = BYTES_PER_WORD;
    localparam int CW  = $clog2(BPW + 1);
    localparam int WW  = DATASIZE * BPW;

    flush_state_e      state_q, state_d;
    logic [CW-1:0]     n_q;
    logic [CW-1:0]     n_eff;
    logic              p_q;
    logic [WW-1:0]     asm_q;
    logic [WW-1:0]     load_data;
    logic [BPW-1:0]    load_keep;
    logic              out_free;
    logic              word_full;
    logic              emit_flush;
    logic              xfer;
    logic              rd_room;
    logic              flush_done_q;
    logic [CNT_W-1:0]  cnt_q;

    // The landing byte counts toward the word, so the last lane bypasses straight
    // into the output register and reads continue without a bubble.
    assign n_eff      = n_q + CW'(p_q);
    assign out_free   = !o_word_valid || i_word_ready;
    assign word_full  = (n_eff == CW'(BPW));
    assign emit_flush = (state_q == FLUSH_EMIT) && (n_q != '0);
    assign xfer       = (word_full || emit_flush) && out_free;
    assign rd_room    = xfer || (n_eff < CW'(BPW));
    assign o_rd_en    = !i_rd_rst && !i_empty && (state_q == RUN) && rd_room;

    always_comb begin
        load_data = '0;
        for (int k = 0; k < BPW; k++) begin
            if (CW'(k) >= n_eff) begin
                load_data[k*DATASIZE +: DATASIZE] = PAD_BYTE;
            end else if (p_q && (CW'(k) == n_q)) begin
                load_data[k*DATASIZE +: DATASIZE] = i_rd_data;
            end else begin
                load_data[k*DATASIZE +: DATASIZE] = asm_q[k*DATASIZE +: DATASIZE];
            end
        end
        load_keep = BPW'(lane_mask(32'(n_eff)));
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:        if (i_flush) state_d = FLUSH_WAIT;
            FLUSH_WAIT: if (!p_q && (n_q != CW'(BPW))) state_d = FLUSH_EMIT;
            FLUSH_EMIT: if ((n_q == '0) || xfer) state_d = RUN;
            default:    state_d = RUN;
        endcase
    end

    always_ff @(posedge i_rd_clk) begin
        if (i_rd_rst) begin
            state_q      <= RUN;
            n_q          <= '0;
            p_q          <= 1'b0;
            asm_q        <= '0;
            flush_done_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            p_q          <= o_rd_en;
            flush_done_q <= (state_q == FLUSH_EMIT) && ((n_q == '0) || xfer);
            if (o_word_valid && i_word_ready) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (xfer) begin
                n_q <= '0;
            end else if (p_q) begin
                n_q <= n_q + CW'(1);
                for (int k = 0; k < BPW; k++) begin
                    if (CW'(k) == n_q) begin
                        asm_q[k*DATASIZE +: DATASIZE] <= i_rd_data;
                    end
                end
            end
        end
    end

    assign o_flush_done = flush_done_q;
    assign o_word_cnt   = cnt_q;

    fifo_word_out_reg #(
        .DATA_W (WW),
        .KEEP_W (BPW)
    ) u_out_reg (
        .clk       (i_rd_clk),
        .rst       (i_rd_rst),
        .load      (xfer),
        .load_data (load_data),
        .load_keep (load_keep),
        .ready     (i_word_ready),
        .data      (o_word_data),
        .keep      (o_word_keep),
        .valid     (o_word_valid)
    );

endmodule

// File: tb/tb_fifo_rd_word_packer.sv
// tb/tb_fifo_rd_word_packer.sv - randomized scoreboard bench for fifo_rd_word_packer
module tb_fifo_rd_word_packer;

    localparam int BPW = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        empty;
    logic        rd_en;
    logic [7:0]  rd_data = 8'h00;
    logic        flush = 1'b0;
    logic [31:0] word_data;
    logic [3:0]  keep;
    logic        valid;
    logic        ready = 1'b0;
    logic        flush_done;
    logic [15:0] word_cnt;

    always #5 clk = ~clk;

    fifo_rd_word_packer #(
        .DATASIZE       (8),
        .BYTES_PER_WORD (BPW),
        .PAD_BYTE       (8'h00),
        .CNT_W          (16)
    ) dut (
        .i_rd_clk     (clk),
        .i_rd_rst     (rst),
        .i_empty      (empty),
        .o_rd_en      (rd_en),
        .i_rd_data    (rd_data),
        .i_flush      (flush),
        .o_word_data  (word_data),
        .o_word_keep  (keep),
        .o_word_valid (valid),
        .i_word_ready (ready),
        .o_flush_done (flush_done),
        .o_word_cnt   (word_cnt)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // FIFO model: registered read data one cycle after rd_en
    logic [7:0] fifo_q[$];
    logic       fifo_empty = 1'b1;
    logic       hold_empty = 1'b0;
    int         cyc  = 0;
    int         pops = 0;
    int         pop_cyc[$];

    assign empty = fifo_empty || hold_empty;

    always @(posedge clk) begin
        cyc++;
        if (rd_en) chk("rd_en_while_empty", empty, 1'b0);
        if (rd_en && !empty) begin
            rd_data <= fifo_q.pop_front();
            pops++;
            pop_cyc.push_back(cyc);
            fifo_empty <= (fifo_q.size() == 0);
        end else begin
            rd_data <= 8'($urandom);
        end
    end

    // Scoreboard: bytes grouped in push order, four per word or cut by a flush
    logic [7:0]  pending[$];
    logic [31:0] exp_data_q[$];
    logic [3:0]  exp_keep_q[$];
    int          exp_done  = 0;
    int          done_seen = 0;

    task automatic model_emit();
        logic [31:0] w = 32'h0;
        for (int i = 0; i < pending.size(); i++) w |= 32'(pending[i]) << (8 * i);
        exp_data_q.push_back(w);
        exp_keep_q.push_back(4'((1 << pending.size()) - 1));
        pending.delete();
    endtask

    task automatic push_byte(input logic [7:0] b);
        fifo_q.push_back(b);
        fifo_empty <= 1'b0;
        pending.push_back(b);
        if (pending.size() == BPW) model_emit();
    endtask

    task automatic model_flush();
        if (pending.size() > 0) model_emit();
        exp_done++;
    endtask

    int          model_cnt  = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data  = 32'h0;
    logic [3:0]  prev_keep  = 4'h0;

    always @(negedge clk) begin
        if (rst) begin
            model_cnt  = 0;
            prev_stall = 1'b0;
        end else begin
            chk("word_cnt", word_cnt, 16'(model_cnt));
            if (prev_stall) begin
                chk("stall_valid", valid, 1'b1);
                chk("stall_data", word_data, prev_data);
                chk("stall_keep", keep, prev_keep);
            end
            if (flush_done) done_seen++;
            if (valid && ready) begin
                chk("word_expected", exp_data_q.size() > 0, 1'b1);
                if (exp_data_q.size() > 0) begin
                    chk("word_data", word_data, exp_data_q.pop_front());
                    chk("word_keep", keep, exp_keep_q.pop_front());
                end
                model_cnt++;
            end
            prev_stall = valid && !ready;
            prev_data  = word_data;
            prev_keep  = keep;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        while ((fifo_q.size() != 0 || exp_data_q.size() != 0 || valid) && t < 3000) begin
            step(1);
            t++;
        end
        chk(name, t < 3000, 1'b1);
        step(3);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_valid"}, valid, 1'b0);
        chk({tag, "_data"}, word_data, 32'h0);
        chk({tag, "_keep"}, keep, 4'h0);
        chk({tag, "_flush_done"}, flush_done, 1'b0);
        chk({tag, "_cnt"}, word_cnt, 16'h0);
        chk({tag, "_rd_en"}, rd_en, 1'b0);
    endtask

    initial begin
        int base;
        int t;
        int sent;

        step(3);
        check_all_zero("reset");
        rst = 1'b0;

        // Back-to-back full words at full read rate
        ready = 1'b1;
        base  = pops;
        pop_cyc.delete();
        for (int b = 1; b <= 8; b++) push_byte(8'(b));
        chk("model_w0", exp_data_q[0], 32'h04030201);
        chk("model_w1", exp_data_q[1], 32'h08070605);
        wait_idle("t1_idle");
        chk("t1_pops", pops - base, 8);
        chk("t1_span", pop_cyc.size() >= 8 ? pop_cyc[7] - pop_cyc[0] : -1, 7);
        chk("t1_cnt", word_cnt, 16'd2);

        // Downstream stall: reads stop once output and assembly are both full
        ready = 1'b0;
        base  = pops;
        for (int i = 0; i < 16; i++) push_byte(8'($urandom));
        step(20);
        chk("t2_pops_stalled", pops - base, 8);
        chk("t2_valid_stalled", valid, 1'b1);
        ready = 1'b1;
        wait_idle("t2_idle");
        chk("t2_cnt", word_cnt, 16'd6);

        // Partial-word flush, then normal packing resumes
        push_byte(8'hAA);
        push_byte(8'hBB);
        push_byte(8'hCC);
        step(5);
        flush = 1'b1;
        model_flush();
        chk("model_partial_data", exp_data_q.size() == 1 ? exp_data_q[0] : 32'hFFFF_FFFF, 32'h00CCBBAA);
        chk("model_partial_keep", exp_keep_q.size() == 1 ? exp_keep_q[0] : 4'h0, 4'h7);
        step(1);
        flush = 1'b0;
        wait_idle("t3_idle");
        chk("t3_flush_done", done_seen, exp_done);
        for (int b = 8'h11; b <= 8'h14; b++) push_byte(8'(b));
        chk("model_w_resume", exp_data_q.size() == 1 ? exp_data_q[0] : 32'h0, 32'h14131211);
        wait_idle("t3b_idle");
        chk("t3_cnt", word_cnt, 16'd8);

        // Flush with nothing assembled
        flush = 1'b1;
        model_flush();
        step(1);
        flush = 1'b0;
        step(10);
        chk("t4_flush_done", done_seen, 2);
        chk("t4_cnt", word_cnt, 16'd8);
        chk("t4_valid", valid, 1'b0);

        // Reset with two lanes assembled and one byte in flight
        base = pops;
        push_byte(8'h31);
        push_byte(8'h32);
        push_byte(8'h33);
        t = 0;
        while (pops - base < 3 && t < 50) begin
            step(1);
            t++;
        end
        chk("t5_inflight", pops - base, 3);
        rst = 1'b1;
        pending.delete();
        step(1);
        check_all_zero("t5_reset");
        rst = 1'b0;
        for (int b = 8'h21; b <= 8'h24; b++) push_byte(8'(b));
        chk("model_w_after_rst", exp_data_q.size() == 1 ? exp_data_q[0] : 32'h0, 32'h24232221);
        wait_idle("t5_idle");
        chk("t5_cnt", word_cnt, 16'd1);

        // Random empty/ready traffic, 1000 bytes from a clean reset
        rst = 1'b1;
        step(1);
        rst  = 1'b0;
        sent = 0;
        t    = 0;
        while (sent < 1000 && t < 20000) begin
            ready      = ($urandom_range(0, 3) != 0);
            hold_empty = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 1) begin
                push_byte(8'($urandom));
                sent++;
            end
            step(1);
            t++;
        end
        hold_empty = 1'b0;
        ready      = 1'b1;
        chk("t6_sent", sent, 1000);
        wait_idle("t6_idle");
        chk("t6_cnt", word_cnt, 16'd250);
        chk("t6_flush_done", done_seen, exp_done);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        n_checks++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
